// File: rtl/rr_grant_arbiter8.sv
// Round-robin arbiter for 8 requesters with registered one-hot grant,
// binary owner index, and an optional hold-timeout preemption.
module rr_grant_arbiter8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout
);

    // Handshake: requester i asserts req[i] and keeps it high for as long as it
    // wants the resource; it owns the resource while grant[i]=1 and releases it
    // by dropping req[i]. A grant can also end by hold timeout (timeout pulse).

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam bit         TIMEOUT_EN = (MAX_HOLD != 0);
    localparam logic [7:0] HOLD_LAST  = 8'(MAX_HOLD - 1);

    state_t     state, state_nxt;
    logic [2:0] ptr, ptr_nxt;
    logic [7:0] hold_cnt, hold_nxt;
    logic [7:0] grant_nxt;
    logic [2:0] idx_nxt;
    logic       valid_nxt;
    logic       timeout_nxt;

    logic [2:0] cand;
    logic [2:0] pick_idx;
    logic       pick_found;

    // First set request scanning upward from ptr, wrapping mod 8.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = ptr;
        cand       = ptr;
        for (int i = 0; i < 8; i++) begin
            cand = ptr + 3'(i);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        hold_nxt    = hold_cnt;
        grant_nxt   = grant;
        idx_nxt     = grant_idx;
        valid_nxt   = grant_valid;
        timeout_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (en && pick_found) begin
                    grant_nxt = 8'b1 << pick_idx;
                    idx_nxt   = pick_idx;
                    valid_nxt = 1'b1;
                    hold_nxt  = 8'd0;
                    state_nxt = GRANT;
                end else begin
                    grant_nxt = 8'h00;
                    valid_nxt = 1'b0;
                end
            end
            GRANT: begin
                // Release wins over an expiry landing on the same edge.
                if (!req[grant_idx]) begin
                    grant_nxt = 8'h00;
                    valid_nxt = 1'b0;
                    ptr_nxt   = grant_idx + 3'd1;
                    hold_nxt  = 8'd0;
                    state_nxt = IDLE;
                end else if (TIMEOUT_EN && hold_cnt == HOLD_LAST) begin
                    grant_nxt   = 8'h00;
                    valid_nxt   = 1'b0;
                    timeout_nxt = 1'b1;
                    ptr_nxt     = grant_idx + 3'd1;
                    hold_nxt    = 8'd0;
                    state_nxt   = IDLE;
                end else if (hold_cnt != 8'hFF) begin
                    hold_nxt = hold_cnt + 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = 8'h00;
                valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= 3'd0;
            hold_cnt    <= 8'd0;
            grant       <= 8'h00;
            grant_idx   <= 3'd0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            hold_cnt    <= hold_nxt;
            grant       <= grant_nxt;
            grant_idx   <= idx_nxt;
            grant_valid <= valid_nxt;
            timeout     <= timeout_nxt;
        end
    end

endmodule
